logic_join_unit: RTL and testbench

Parametrised two-operand bitwise logic unit with Bluespec-style ready/enable handshakes on every channel. It holds one operand per input channel, fires when both are present, applies a per-transaction operation (AND/OR/XOR/NOR), and queues results in a DEPTH-entry output FIFO. It is the generalised successor to the single-bit OR handshake block in the same handshake-primitive family, generalised in width, operation and buffering.

---
 rtl/logic_join_pkg.sv | 36 +++
 rtl/logic_join_unit_fifo.sv | 51 +++++
 rtl/logic_join_unit.sv | 100 ++++++++++
 tb/tb_logic_join_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_join_pkg.sv
// Shared types and the bitwise operator for the logic join unit.
// apply_op works on MAX_W-bit vectors; callers truncate to their own width.
package logic_join_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_HAVE_A,
    SLOT_HAVE_B,
    SLOT_BOTH
  } slot_state_t;

  function automatic logic [MAX_W-1:0] apply_op(input op_t op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_join_unit_fifo.sv
// Result FIFO: DEPTH entries, naturally wrapping pointers, head gated to 0 when empty.
// A push into a full FIFO is taken only alongside a same-cycle pop.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/logic_join_unit.sv
// Two-operand bitwise join: one A slot (with op) and one B slot, fired together
// into a result FIFO when both are present and the FIFO can take the result.
module logic_join_unit
  import logic_join_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       a_data,
  input  logic [1:0]             a_op,
  input  logic                   a_en,
  output logic                   a_rdy,
  input  logic [WIDTH-1:0]       b_data,
  input  logic                   b_en,
  output logic                   b_rdy,
  output logic [WIDTH-1:0]       y_data,
  output logic                   y_rdy,
  input  logic                   y_en,
  output logic [$clog2(DEPTH):0] y_count
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_t              op_q;
  logic             a_full;
  logic             b_full;
  logic             a_next;
  logic             b_next;
  logic             a_acc;
  logic             b_acc;
  logic             fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] result;

  assign a_full = (state_q == SLOT_HAVE_A) || (state_q == SLOT_BOTH);
  assign b_full = (state_q == SLOT_HAVE_B) || (state_q == SLOT_BOTH);

  // A full FIFO can still take the result when the consumer pops this cycle.
  assign fire  = a_full & b_full & (~fifo_full | y_en);
  assign a_rdy = ~a_full | fire;
  assign b_rdy = ~b_full | fire;
  assign a_acc = a_en & a_rdy;
  assign b_acc = b_en & b_rdy;
  assign y_rdy = ~fifo_empty;

  assign result = WIDTH'(apply_op(op_q, MAX_W'(a_q), MAX_W'(b_q)));

  always_comb begin
    state_d = state_q;
    a_next  = (a_full & ~fire) | a_acc;
    b_next  = (b_full & ~fire) | b_acc;
    case ({a_next, b_next})
      2'b00:   state_d = SLOT_EMPTY;
      2'b10:   state_d = SLOT_HAVE_A;
      2'b01:   state_d = SLOT_HAVE_B;
      2'b11:   state_d = SLOT_BOTH;
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_AND;
    end else begin
      if (a_acc) begin
        a_q  <= a_data;
        op_q <= op_t'(a_op);
      end
      if (b_acc) b_q <= b_data;
    end
  end

  result_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fire),
    .push_data (result),
    .pop       (y_en),
    .head      (y_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (y_count)
  );

endmodule

// File: tb/tb_logic_join_unit.sv
// Directed bench for logic_join_unit (WIDTH=8, DEPTH=4): op table plus
// hand-written staggered, backpressure, full-pop and async-reset sequences.
module tb_logic_join_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] a_data;
  logic [1:0]       a_op;
  logic             a_en;
  logic             a_rdy;
  logic [WIDTH-1:0] b_data;
  logic             b_en;
  logic             b_rdy;
  logic [WIDTH-1:0] y_data;
  logic             y_rdy;
  logic             y_en;
  logic [2:0]       y_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [1:0] op;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [4];

  logic_join_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .a_data  (a_data),
    .a_op    (a_op),
    .a_en    (a_en),
    .a_rdy   (a_rdy),
    .b_data  (b_data),
    .b_en    (b_en),
    .b_rdy   (b_rdy),
    .y_data  (y_data),
    .y_rdy   (y_rdy),
    .y_en    (y_en),
    .y_count (y_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [1:0] op,
                                input logic [7:0] b, input logic ae, input logic be);
    a_data = a;
    a_op   = op;
    b_data = b;
    a_en   = ae;
    b_en   = be;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_a_rdy"},   a_rdy,   1);
    check_output({tag, "_b_rdy"},   b_rdy,   1);
    check_output({tag, "_y_rdy"},   y_rdy,   0);
    check_output({tag, "_y_data"},  y_data,  0);
    check_output({tag, "_y_count"}, y_count, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got;
    logic [7:0] h;
    logic [7:0] v;
    logic took;

    vecs[0] = '{a: 8'hF0, op: 2'b00, b: 8'h3C, y: 8'h30};
    vecs[1] = '{a: 8'hF0, op: 2'b01, b: 8'h3C, y: 8'hFC};
    vecs[2] = '{a: 8'hF0, op: 2'b10, b: 8'h3C, y: 8'hCC};
    vecs[3] = '{a: 8'hF0, op: 2'b11, b: 8'h3C, y: 8'h03};

    RST  = 1'b1;
    y_en = 1'b0;
    apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset_values("reset");

    // Each op: result appears two edges after the accept.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].op, vecs[i].b, 1'b1, 1'b1);
      @(negedge CLK);
      apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
      check_output("op_lat_one_edge", y_rdy, 0);
      @(negedge CLK);
      check_output("op_lat_two_edges", y_rdy, 1);
      check_output("op_result", y_data, vecs[i].y);
      check_output("op_count", y_count, 1);
      y_en = 1'b1;
      @(negedge CLK);
      y_en = 1'b0;
      check_output("op_popped", y_count, 0);
    end

    // Staggered arrival, with a second A attempt that must be blocked.
    apply_stimulus(8'h0F, 2'b01, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output("stagger_a_rdy", a_rdy, 0);
      check_output("stagger_b_rdy", b_rdy, 1);
      if (k == 1) apply_stimulus(8'hFF, 2'b00, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      a_en = 1'b0;
    end
    apply_stimulus(8'h00, 2'b00, 8'hA0, 1'b0, 1'b1);
    @(negedge CLK);
    b_en = 1'b0;
    @(negedge CLK);
    check_output("stagger_y_rdy", y_rdy, 1);
    check_output("stagger_result", y_data, 8'hAF);
    y_en = 1'b1;
    @(negedge CLK);
    y_en = 1'b0;

    // Backpressure: five pairs fill FIFO plus slots, the sixth is held off.
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(8'(i), 2'b00, 8'hFF, 1'b1, 1'b1);
      #1;
      check_output("bp_accept_rdy", a_rdy & b_rdy, 1);
      @(negedge CLK);
    end
    apply_stimulus(8'h06, 2'b00, 8'hFF, 1'b1, 1'b1);
    #1;
    check_output("bp_count_sat", y_count, 4);
    check_output("bp_a_rdy", a_rdy, 0);
    check_output("bp_b_rdy", b_rdy, 0);
    repeat (2) @(negedge CLK);
    check_output("bp_count_hold", y_count, 4);
    check_output("bp_head", y_data, 8'h01);
    y_en = 1'b1;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (y_rdy) begin
        check_output("bp_drain_order", y_data, 32'(got + 1));
        got++;
      end
      took = a_en & a_rdy;
      @(negedge CLK);
      if (took) apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
    end
    y_en = 1'b0;
    check_output("bp_drain_total", got, 6);
    check_output("bp_drained_count", y_count, 0);

    // Full FIFO with one pop per step: count holds at 4 over several pointer laps.
    v = 8'h10;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(v, 2'b01, 8'h00, 1'b1, 1'b1);
      @(negedge CLK);
      v++;
    end
    apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
    #1;
    check_output("lap_fill_count", y_count, 4);
    check_output("lap_fill_a_rdy", a_rdy, 0);
    h = 8'h10;
    for (int it = 0; it < 10; it++) begin
      y_en = 1'b1;
      apply_stimulus(v, 2'b01, 8'h00, 1'b1, 1'b1);
      #1;
      check_output("lap_head", y_data, h);
      check_output("lap_rdy_with_pop", a_rdy, 1);
      @(negedge CLK);
      y_en = 1'b0;
      apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
      h++;
      v++;
      #1;
      check_output("lap_count", y_count, 4);
      check_output("lap_stall_rdy", a_rdy, 0);
    end
    y_en = 1'b1;
    got  = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      #1;
      if (y_rdy) begin
        check_output("lap_drain_order", y_data, h);
        h++;
        got++;
      end
      @(negedge CLK);
    end
    y_en = 1'b0;
    check_output("lap_drain_total", got, 5);
    check_output("lap_drained_count", y_count, 0);

    // Async reset with two results queued and A held.
    apply_stimulus(8'h01, 2'b00, 8'hFF, 1'b1, 1'b1);
    @(negedge CLK);
    apply_stimulus(8'h02, 2'b00, 8'hFF, 1'b1, 1'b1);
    @(negedge CLK);
    apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    apply_stimulus(8'h77, 2'b01, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    a_en = 1'b0;
    #1;
    check_output("pre_rst_count", y_count, 2);
    check_output("pre_rst_a_rdy", a_rdy, 0);
    #1;
    RST = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge CLK);
    check_output("rst_held_count", y_count, 0);
    RST = 1'b0;
    apply_stimulus(8'h55, 2'b10, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    a_en = 1'b0;
    #1;
    check_output("post_rst_a_held", a_rdy, 0);
    apply_stimulus(8'h00, 2'b00, 8'hFF, 1'b1, 1'b1);
    @(negedge CLK);
    apply_stimulus(8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
    check_output("post_rst_lat", y_rdy, 0);
    @(negedge CLK);
    check_output("post_rst_y_rdy", y_rdy, 1);
    check_output("post_rst_result", y_data, 8'hAA);
    check_output("post_rst_count", y_count, 1);
    y_en = 1'b1;
    @(negedge CLK);
    y_en = 1'b0;
    check_output("post_rst_empty", y_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
